// File: rtl/beacon_power_sequencer_if.sv
// Handshake bundle between the beacon control logic and the power sequencer.
// W sets the duty command width and must match the sequencer instance.
interface beacon_power_sequencer_if #(
  parameter int unsigned W = 8
);
  logic         tick;
  logic         lights_req;
  logic         src_req;
  logic         cap_ok;
  logic         grid_switch;
  logic         pwm_enable;
  logic [W-1:0] duty;
  logic         busy;
  logic         fallback;

  modport master (
    output tick, lights_req, src_req, cap_ok,
    input  grid_switch, pwm_enable, duty, busy, fallback
  );

  modport slave (
    input  tick, lights_req, src_req, cap_ok,
    output grid_switch, pwm_enable, duty, busy, fallback
  );
endinterface

// File: rtl/beacon_power_sequencer.sv
// Beacon light power path sequencer: grid/capacitor source select with break-before-make
// dead time and PWM soft-start. Soft-start ramp is enabled by defining BEACON_SEQ_RAMP_EN.
module beacon_power_sequencer #(
  parameter int unsigned DEAD_TICKS   = 4,
  parameter int unsigned SETTLE_TICKS = 2,
  parameter int unsigned RAMP_STEP    = 8,
  parameter int unsigned DUTY_MAX     = 255,
  parameter int unsigned W            = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  beacon_power_sequencer_if.slave       bus
);

`ifdef BEACON_SEQ_RAMP_EN
  localparam bit RAMP_EN = 1'b1;
`else
  localparam bit RAMP_EN = 1'b0;
`endif

  localparam int unsigned CNT_MAX = (DEAD_TICKS > SETTLE_TICKS) ? DEAD_TICKS : SETTLE_TICKS;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [W-1:0] DUTY_FULL     = W'(DUTY_MAX);
  localparam logic [W:0]   DUTY_FULL_EXT = (W+1)'(DUTY_MAX);
  localparam logic [W:0]   STEP_EXT      = (W+1)'(RAMP_STEP);

  typedef enum logic [2:0] {
    S_OFF,
    S_DRAIN,
    S_SWITCH,
    S_RAMP,
    S_ON
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               grid_q, grid_d;
  logic               pwm_q, pwm_d;
  logic [W-1:0]       duty_q, duty_d;
  logic               busy_q, busy_d;
  logic               fallback_q, fallback_d;
  logic               src_eff_c;
  logic [W:0]         ramp_sum_c;

  assign src_eff_c  = bus.src_req & bus.cap_ok & ~fallback_q;
  assign ramp_sum_c = {1'b0, duty_q} + STEP_EXT;

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_OFF;
      cnt_q      <= '0;
      grid_q     <= 1'b0;
      pwm_q      <= 1'b0;
      duty_q     <= '0;
      busy_q     <= 1'b0;
      fallback_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      grid_q     <= grid_d;
      pwm_q      <= pwm_d;
      duty_q     <= duty_d;
      busy_q     <= busy_d;
      fallback_q <= fallback_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grid_d  = grid_q;
    duty_d  = duty_q;
    // Clearing on src_req=0 takes priority over a coincident set
    fallback_d = bus.src_req ? (fallback_q | (grid_q & ~bus.cap_ok)) : 1'b0;

    unique case (state_q)
      S_OFF: begin
        duty_d = '0;
        if (bus.lights_req) begin
          cnt_d = '0;
          if (src_eff_c != grid_q) begin
            state_d = S_DRAIN;
          end else if (RAMP_EN) begin
            state_d = S_RAMP;
          end else begin
            state_d = S_ON;
            duty_d  = DUTY_FULL;
          end
        end
      end

      S_DRAIN: begin
        duty_d = '0;
        if (bus.tick) begin
          if (cnt_q == CNT_W'(DEAD_TICKS - 1)) begin
            cnt_d   = '0;
            grid_d  = src_eff_c;
            state_d = S_SWITCH;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      S_SWITCH: begin
        duty_d = '0;
        if (bus.tick) begin
          if (cnt_q == CNT_W'(SETTLE_TICKS - 1)) begin
            cnt_d = '0;
            if (!bus.lights_req) begin
              state_d = S_OFF;
            end else if (RAMP_EN) begin
              state_d = S_RAMP;
            end else begin
              state_d = S_ON;
              duty_d  = DUTY_FULL;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      S_RAMP, S_ON: begin
        if (state_q == S_ON) begin
          duty_d = DUTY_FULL;
        end
        if (!bus.lights_req) begin
          state_d = S_OFF;
          duty_d  = '0;
        end else if (src_eff_c != grid_q) begin
          state_d = S_DRAIN;
          duty_d  = '0;
          cnt_d   = '0;
        end else if (state_q == S_RAMP && bus.tick) begin
          // Sum is one bit wider than duty so saturation never sees a wrapped value
          if (ramp_sum_c >= DUTY_FULL_EXT) begin
            duty_d  = DUTY_FULL;
            state_d = S_ON;
          end else begin
            duty_d = ramp_sum_c[W-1:0];
          end
        end
      end

      default: begin
        state_d = S_OFF;
        duty_d  = '0;
      end
    endcase

    pwm_d  = (state_d == S_RAMP) || (state_d == S_ON);
    busy_d = (state_d == S_DRAIN) || (state_d == S_SWITCH) || (state_d == S_RAMP);
  end

  assign bus.grid_switch = grid_q;
  assign bus.pwm_enable  = pwm_q;
  assign bus.duty        = duty_q;
  assign bus.busy        = busy_q;
  assign bus.fallback    = fallback_q;

endmodule

// File: tb/tb_beacon_power_sequencer.sv
// Directed bench for beacon_power_sequencer; expectations follow BEACON_SEQ_RAMP_EN.
module tb_beacon_power_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  beacon_power_sequencer_if #(.W(8)) bus ();

  beacon_power_sequencer #(
    .DEAD_TICKS  (4),
    .SETTLE_TICKS(2),
    .RAMP_STEP   (8),
    .DUTY_MAX    (255),
    .W           (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One tick pulse followed by one idle clock
  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      bus.tick = 1'b1;
      step();
      bus.tick = 1'b0;
      step();
    end
  endtask

`ifdef BEACON_SEQ_RAMP_EN
  task automatic ramp_up(input string tag);
    int exp;
    for (int k = 1; k <= 32; k++) begin
      tick_n(1);
      exp = (k * 8 > 255) ? 255 : k * 8;
      chk($sformatf("%s_duty%0d", tag, k), 32'(bus.duty), 32'(exp));
    end
    chk({tag, "_busy_done"}, 32'(bus.busy), 32'd0);
  endtask
`endif

  initial begin
    bus.tick       = 1'b0;
    bus.lights_req = 1'b0;
    bus.src_req    = 1'b0;
    bus.cap_ok     = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    chk("rst_grid", 32'(bus.grid_switch), 32'd0);
    chk("rst_pwm",  32'(bus.pwm_enable),  32'd0);
    chk("rst_duty", 32'(bus.duty),        32'd0);
    chk("rst_busy", 32'(bus.busy),        32'd0);
    chk("rst_fb",   32'(bus.fallback),    32'd0);

    // Grid start
    bus.lights_req = 1'b1;
    step();
    chk("gs_pwm", 32'(bus.pwm_enable), 32'd1);
`ifdef BEACON_SEQ_RAMP_EN
    chk("gs_duty0", 32'(bus.duty), 32'd0);
    chk("gs_busy",  32'(bus.busy), 32'd1);
    ramp_up("gs");
`else
    chk("gs_duty", 32'(bus.duty), 32'd255);
    chk("gs_busy", 32'(bus.busy), 32'd0);
`endif
    chk("gs_grid", 32'(bus.grid_switch), 32'd0);

    // Source change to capacitor; the coincident tick must not be counted
    bus.src_req = 1'b1;
    bus.tick    = 1'b1;
    step();
    bus.tick = 1'b0;
    chk("sc_pwm_off", 32'(bus.pwm_enable), 32'd0);
    chk("sc_duty0",   32'(bus.duty),       32'd0);
    chk("sc_busy",    32'(bus.busy),       32'd1);
    tick_n(3);
    chk("sc_grid_3", 32'(bus.grid_switch), 32'd0);
    tick_n(1);
    chk("sc_grid_4", 32'(bus.grid_switch), 32'd1);
    chk("sc_pwm_sw", 32'(bus.pwm_enable),  32'd0);
    tick_n(1);
    chk("sc_pwm_settle1", 32'(bus.pwm_enable), 32'd0);
    tick_n(1);
    chk("sc_pwm_on", 32'(bus.pwm_enable), 32'd1);
`ifdef BEACON_SEQ_RAMP_EN
    chk("sc_ramp_start", 32'(bus.duty), 32'd0);
    ramp_up("sc");
`else
    chk("sc_duty_full", 32'(bus.duty), 32'd255);
`endif

    // Capacitor collapse forces grid
    bus.cap_ok = 1'b0;
    step();
    chk("cc_fb",  32'(bus.fallback),   32'd1);
    chk("cc_pwm", 32'(bus.pwm_enable), 32'd0);
    bus.cap_ok = 1'b1;
    tick_n(3);
    chk("cc_grid_3", 32'(bus.grid_switch), 32'd1);
    tick_n(1);
    chk("cc_grid_4", 32'(bus.grid_switch), 32'd0);
    chk("cc_fb_hold", 32'(bus.fallback), 32'd1);
    tick_n(2);
    chk("cc_pwm_on", 32'(bus.pwm_enable), 32'd1);
    chk("cc_grid_hold", 32'(bus.grid_switch), 32'd0);
    bus.src_req = 1'b0;
    step();
    chk("cc_fb_clr", 32'(bus.fallback), 32'd0);
    chk("cc_pwm_stay", 32'(bus.pwm_enable), 32'd1);

    // Abort (mid-ramp at duty 64 when the ramp is built in)
`ifdef BEACON_SEQ_RAMP_EN
    tick_n(8);
    chk("ab_duty64", 32'(bus.duty), 32'd64);
`endif
    bus.lights_req = 1'b0;
    step();
    chk("ab_duty", 32'(bus.duty),        32'd0);
    chk("ab_pwm",  32'(bus.pwm_enable),  32'd0);
    chk("ab_busy", 32'(bus.busy),        32'd0);
    chk("ab_grid", 32'(bus.grid_switch), 32'd0);

    // lights_req drops during DRAIN: switch still completes, then OFF
    bus.lights_req = 1'b1;
    bus.src_req    = 1'b1;
    step();
    chk("lf_busy", 32'(bus.busy), 32'd1);
    bus.lights_req = 1'b0;
    tick_n(4);
    chk("lf_grid", 32'(bus.grid_switch), 32'd1);
    tick_n(2);
    chk("lf_off_busy", 32'(bus.busy),        32'd0);
    chk("lf_off_pwm",  32'(bus.pwm_enable),  32'd0);
    chk("lf_off_grid", 32'(bus.grid_switch), 32'd1);

    // Back to grid, then a mismatch while lit re-enters DRAIN
    bus.lights_req = 1'b1;
    bus.src_req    = 1'b0;
    step();
    chk("rg_busy", 32'(bus.busy), 32'd1);
    tick_n(4);
    chk("rg_grid", 32'(bus.grid_switch), 32'd0);
    tick_n(2);
    chk("rg_pwm", 32'(bus.pwm_enable), 32'd1);
    bus.src_req = 1'b1;
    step();
    chk("mm_pwm",  32'(bus.pwm_enable), 32'd0);
    chk("mm_busy", 32'(bus.busy),       32'd1);
    tick_n(4);
    chk("mm_grid", 32'(bus.grid_switch), 32'd1);
    tick_n(1);

    // Asynchronous reset in SWITCH on capacitor
    #2;
    rst = 1'b1;
    #1;
    chk("ar_grid", 32'(bus.grid_switch), 32'd0);
    chk("ar_pwm",  32'(bus.pwm_enable),  32'd0);
    chk("ar_duty", 32'(bus.duty),        32'd0);
    chk("ar_busy", 32'(bus.busy),        32'd0);
    chk("ar_fb",   32'(bus.fallback),    32'd0);
    bus.src_req = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
    chk("ar_restart_pwm",  32'(bus.pwm_enable),  32'd1);
    chk("ar_restart_grid", 32'(bus.grid_switch), 32'd0);
`ifdef BEACON_SEQ_RAMP_EN
    chk("ar_restart_busy", 32'(bus.busy), 32'd1);
    chk("ar_restart_duty", 32'(bus.duty), 32'd0);
`else
    chk("ar_restart_busy", 32'(bus.busy), 32'd0);
    chk("ar_restart_duty", 32'(bus.duty), 32'd255);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/beacon_power_sequencer.md
# beacon_power_sequencer

Sequences the beacon light power path: chooses grid or supercapacitor as the light source, enforces break-before-make dead time on every source change, and soft-starts the PWM duty. It sits between the beacon FSM/MPPT logic (which request lights and source) and the 3-phase PWM generator plus grid switch. All waits are counted in `tick` pulses from the slow state-machine clock divider. Everything else runs on the 50 MHz system clock.

## Interface
- `DEAD_TICKS`, default 4: ticks with PWM disabled before the source switch changes (≥1).
- `SETTLE_TICKS`, default 2: ticks after the source switch changes before PWM is re-enabled (≥1).
- `RAMP_STEP`, default 8: duty increment per tick during soft-start (≥1).
- `DUTY_MAX`, default 255: final duty value (≥1, < 2^W).
- `W`, default 8: duty width.

- `clk` input 1: system clock. One clock; reset is asynchronous and active-high.
- `rst` input 1: asynchronous active-high reset.
- `tick` input 1: single-cycle timing strobe.
- `lights_req` input 1: lights requested on.
- `src_req` input 1: requested source, 0 = grid, 1 = capacitor.
- `cap_ok` input 1: capacitor voltage is adequate to drive the lights.
- `grid_switch` output 1: applied source, 0 = grid, 1 = capacitor.
- `pwm_enable` output 1: PWM generator enable.
- `duty` output W: PWM duty command.
- `busy` output 1: high in DRAIN, SWITCH and RAMP.
- `fallback` output 1: sticky flag. Set when the block forces grid because `cap_ok` dropped.

## Operation
- States: OFF, DRAIN, SWITCH, RAMP, ON.
- Effective source `src_eff = src_req & cap_ok & ~fallback`.
- Reset values: state OFF, `grid_switch`=0, `pwm_enable`=0, `duty`=0, `busy`=0, `fallback`=0, tick counter 0.
- OFF: `pwm_enable`=0 and `duty`=0.
  - If `lights_req`=1: go to DRAIN when `src_eff` ≠ `grid_switch`; otherwise go to RAMP.
- DRAIN: `pwm_enable`=0 and `duty`=0.
  - Leave after DEAD_TICKS ticks have been counted in this state.
  - On exit, `grid_switch` ← `src_eff`, which is re-evaluated at exit. Then go to SWITCH.
- SWITCH: `pwm_enable`=0.
  - After SETTLE_TICKS ticks, go to RAMP if `lights_req`=1, else go to OFF.
- RAMP: `pwm_enable`=1.
  - On each tick: `duty` ← min(`duty`+RAMP_STEP, DUTY_MAX). The sum is computed W+1 bits wide, so it never wraps.
  - When `duty` = DUTY_MAX, go to ON.
- ON: `pwm_enable`=1 and `duty`=DUTY_MAX.
- Abort from RAMP or ON, evaluated every `clk` with priority top to bottom:
  - `lights_req`=0: go to OFF immediately. `duty`←0 and `pwm_enable`←0 on the same edge.
  - `src_eff` ≠ `grid_switch`: go to DRAIN immediately. `duty`←0 and `pwm_enable`←0.
- `fallback`:
  - Set on the edge where `grid_switch`=1 and `cap_ok`=0, in any state. `src_eff` then forces grid, which triggers the DRAIN path.
  - Cleared on the first edge with `src_req`=0.
  - If set and clear coincide, clear wins.
- Source requests arriving during DRAIN or SWITCH do not restart the counters. DRAIN exit uses the latest `src_eff`. A mismatch found in RAMP re-enters DRAIN.
- `lights_req` falling during DRAIN or SWITCH: the sequence completes (the source still switches), then the block goes to OFF.
- `rst` mid-operation: all outputs return to reset values asynchronously. `grid_switch` therefore drops to grid with PWM off.

## Timing
- Registered outputs; state transitions on the rising `clk` edge.
- A `tick` coincident with state entry is not counted. Counting starts with the next tick.
- DRAIN lasts exactly DEAD_TICKS counted ticks. SWITCH lasts exactly SETTLE_TICKS.
- `grid_switch` changes on the DRAIN→SWITCH edge only. PWM is guaranteed low for ≥ DEAD_TICKS ticks before and ≥ SETTLE_TICKS ticks after the change.
- Ramp duration is ceil(DUTY_MAX/RAMP_STEP) ticks. With defaults this is 32 ticks, and `duty` reads 8, 16, …, 248, 255.
- Abort latency is 1 `clk` from the input change to `pwm_enable`=0.

## Configuration
- `BEACON_SEQ_RAMP_EN` defined: soft-start ramp exactly as described.
- Not defined: the RAMP state is bypassed. SWITCH, and OFF with a matching source, go directly to ON, and `duty` jumps to DUTY_MAX on that edge. All dead-time behaviour is unchanged.

## Test plan
- Grid start: reset, `lights_req`=1, `src_req`=0. With the macro defined, duty steps 8…248, 255 over 32 ticks, then ON; `grid_switch` stays 0 throughout.
- Source change: from ON, set `src_req`=1 with `cap_ok`=1.
  - `pwm_enable`=0 next `clk`.
  - `grid_switch`=1 after 4 ticks.
  - `pwm_enable`=1 after 2 more ticks, then the ramp restarts from 0.
- Cap collapse: in ON on capacitor, drop `cap_ok`.
  - `fallback`=1 and `pwm_enable`=0 next `clk`.
  - `grid_switch`=0 after 4 ticks.
  - `fallback` clears when `src_req` goes to 0.
- Abort mid-ramp: at duty=64, set `lights_req`=0. Duty and `pwm_enable` are 0 one `clk` later; state OFF; `grid_switch` unchanged.
- Async reset in SWITCH with `grid_switch`=1: all outputs are 0 immediately without waiting for a `clk` edge. After release, with `lights_req`=1 and `src_req`=0, the block goes straight to RAMP.
- Macro undefined: grid start goes OFF→ON with duty=255 one `clk` after `lights_req`. The source-change scenario goes to duty=255 directly after SWITCH.
